mono_to_stereo_packet_converter: RTL and testbench

Converts the internal mono sample stream (valid-pulse, no backpressure) back into an AXI-Stream master carrying stereo packets.
Each mono sample becomes one two-beat packet: beat 0 is the left channel, beat 1 is the right channel with TLAST. Both beats carry the same sample.
A small FIFO absorbs downstream TREADY stalls. Samples that arrive while the FIFO is full are dropped and flagged.
The block sits between the visualizer/processing path and the audio output DMA or codec transmit path.

---
 rtl/mono_to_stereo_packet_converter.sv | 155 +++++++++++++++
 tb/tb_mono_to_stereo_packet_converter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mono_to_stereo_packet_converter.sv
// Mono-to-stereo AXI-Stream packetiser.
// Each accepted mono sample is emitted as a two-beat packet: left beat, then a
// right beat with TLAST. Both beats carry the sample unchanged. A small FIFO
// absorbs TREADY stalls. A sample that arrives while the FIFO is full, with no
// pop in the same cycle, is dropped and sets the sticky overflow flag.
//
// Ports:
//   M_AXIS_ACLK        clock, rising edge
//   M_AXIS_ARESETN     asynchronous active-low reset
//   mono_sample_valid  single-cycle qualifier for mono_sample
//   mono_sample        mono sample in
//   M_AXIS_TVALID      beat valid (registered)
//   M_AXIS_TDATA       channel sample (registered)
//   M_AXIS_TLAST       high on the right-channel beat (registered)
//   M_AXIS_TREADY      downstream ready
//   fifo_count         registered FIFO occupancy, 0..FIFO_DEPTH
//   overflow           sticky drop flag, cleared only by reset
module mono_to_stereo_packet_converter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  mono_sample_valid,
    input  logic [DATA_WIDTH-1:0] mono_sample,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_LEFT  = 2'd1,
        SEND_RIGHT = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] hold;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  overflow_q;

    logic                  pop_c;
    logic                  wr_c;
    logic                  not_empty_c;

    // Pop/push decisions use the occupancy before any same-cycle write.
    always_comb begin
        pop_c       = 1'b0;
        not_empty_c = (count != '0);
        if (not_empty_c) begin
            if (state == IDLE) begin
                pop_c = 1'b1;
            end else if (state == SEND_RIGHT && M_AXIS_TREADY) begin
                pop_c = 1'b1;
            end
        end
        wr_c = mono_sample_valid && ((count < DEPTH_C) || pop_c);
    end

    // Sample storage; no reset needed, contents are qualified by count.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (wr_c) begin
            mem[wr_ptr] <= mono_sample;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (wr_c && !pop_c) begin
                count <= count + CNT_W'(1);
            end else if (pop_c && !wr_c) begin
                count <= count - CNT_W'(1);
            end
            if (mono_sample_valid && !wr_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Packet FSM with registered AXIS outputs; hold drives TDATA directly.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state    <= IDLE;
            hold     <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        hold     <= mem[rd_ptr];
                        state    <= SEND_LEFT;
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                    end
                end
                SEND_LEFT: begin
                    if (M_AXIS_TREADY) begin
                        state   <= SEND_RIGHT;
                        tlast_q <= 1'b1;
                    end
                end
                SEND_RIGHT: begin
                    if (M_AXIS_TREADY) begin
                        if (pop_c) begin
                            hold    <= mem[rd_ptr];
                            state   <= SEND_LEFT;
                            tlast_q <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                end
            endcase
        end
    end

    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = hold;
    assign M_AXIS_TLAST  = tlast_q;
    assign fifo_count    = count;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_mono_to_stereo_packet_converter.sv
// Self-checking bench for mono_to_stereo_packet_converter.
// Reference model: a sample queue plus "packet in flight / which beat" state,
// stepped once per clock edge from the block's externally visible rules.
module tb_mono_to_stereo_packet_converter;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tready;
    logic [AW:0]   fcount;
    logic          ovf;

    mono_to_stereo_packet_converter #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .M_AXIS_ACLK      (clk),
        .M_AXIS_ARESETN   (rst_n),
        .mono_sample_valid(in_valid),
        .mono_sample      (in_data),
        .M_AXIS_TVALID    (tvalid),
        .M_AXIS_TDATA     (tdata),
        .M_AXIS_TLAST     (tlast),
        .M_AXIS_TREADY    (tready),
        .fifo_count       (fcount),
        .overflow         (ovf)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic          m_busy;
    logic          m_right;
    logic [DW-1:0] m_hold;
    logic          m_ovf;

    function automatic void model_reset();
        m_q.delete();
        m_busy  = 1'b0;
        m_right = 1'b0;
        m_hold  = '0;
        m_ovf   = 1'b0;
    endfunction

    // One clock edge of the abstract model, from the inputs applied now.
    function automatic void model_step(input logic v, input logic [DW-1:0] d, input logic rdy);
        bit hs, pop, wr;
        hs  = m_busy && rdy;
        pop = (m_q.size() > 0) && (!m_busy || (hs && m_right));
        wr  = v && ((m_q.size() < DEPTH) || pop);
        if (pop) begin
            m_hold  = m_q.pop_front();
            m_busy  = 1'b1;
            m_right = 1'b0;
        end else if (hs) begin
            if (!m_right) m_right = 1'b1;
            else begin m_busy = 1'b0; m_right = 1'b0; end
        end
        if (wr) m_q.push_back(d);
        else if (v) m_ovf = 1'b1;
    endfunction

    task automatic tick();
        model_step(in_valid, in_data, tready);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %0b want 0", tvalid); end
        n_vec++; if (tlast  !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %0b want 0", tlast); end
        n_vec++; if (tdata  !== '0)   begin n_err++; $display("FAIL reset_tdata got %h want 0", tdata); end
        n_vec++; if (fcount !== '0)   begin n_err++; $display("FAIL reset_count got %0d want 0", fcount); end
        n_vec++; if (ovf    !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    endtask

    task automatic test_single();
        int rise_cyc = -1;
        apply_reset();
        tready = 1'b1; in_valid = 1'b1; in_data = 32'h0000_1234;
        for (int c = 1; c <= 6; c++) begin
            tick();
            in_valid = 1'b0;
            if (tvalid === 1'b1 && rise_cyc < 0) rise_cyc = c;
            n_vec++; if (tvalid !== m_busy) begin n_err++; $display("FAIL single_tvalid c%0d got %0b want %0b", c, tvalid, m_busy); end
            n_vec++; if (tdata !== m_hold) begin n_err++; $display("FAIL single_tdata c%0d got %h want %h", c, tdata, m_hold); end
            n_vec++; if (tlast !== (m_busy && m_right)) begin n_err++; $display("FAIL single_tlast c%0d got %0b want %0b", c, tlast, m_busy && m_right); end
            n_vec++; if (fcount !== (AW+1)'(m_q.size())) begin n_err++; $display("FAIL single_count c%0d got %0d want %0d", c, fcount, m_q.size()); end
        end
        n_vec++; if (rise_cyc != 2) begin n_err++; $display("FAIL single_latency got %0d want 2", rise_cyc); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        tready = 1'b0; in_valid = 1'b1; in_data = 32'hCAFE_0001;
        tick(); in_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c == 6) tready = 1'b1;
            tick();
            n_vec++; if (tvalid !== m_busy) begin n_err++; $display("FAIL bp_tvalid c%0d got %0b want %0b", c, tvalid, m_busy); end
            n_vec++; if (tdata !== m_hold) begin n_err++; $display("FAIL bp_tdata c%0d got %h want %h", c, tdata, m_hold); end
            n_vec++; if (tlast !== (m_busy && m_right)) begin n_err++; $display("FAIL bp_tlast c%0d got %0b want %0b", c, tlast, m_busy && m_right); end
        end
        n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL bp_done got %0b want 0", tvalid); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got_d[$];
        logic          got_l[$];
        int            gaps = 0;
        apply_reset();
        tready = 1'b1;
        for (int c = 0; c < 40 && got_d.size() < 8; c++) begin
            in_valid = (c < 8) && (c % 2 == 0);
            in_data  = DW'(c / 2 + 1);
            if (tvalid) begin got_d.push_back(tdata); got_l.push_back(tlast); end
            else if (got_d.size() > 0) gaps++;
            tick();
        end
        in_valid = 1'b0;
        n_vec++; if (got_d.size() != 8) begin n_err++; $display("FAIL b2b_beats got %0d want 8", got_d.size()); end
        n_vec++; if (gaps != 0) begin n_err++; $display("FAIL b2b_gap got %0d want 0", gaps); end
        for (int i = 0; i < got_d.size(); i++) begin
            n_vec++; if (got_d[i] !== DW'(i / 2 + 1)) begin n_err++; $display("FAIL b2b_data beat%0d got %h want %h", i, got_d[i], i / 2 + 1); end
            n_vec++; if (got_l[i] !== 1'((i % 2) == 1)) begin n_err++; $display("FAIL b2b_last beat%0d got %0b want %0b", i, got_l[i], (i % 2) == 1); end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] sent[10];
        logic [DW-1:0] got_d[$];
        apply_reset();
        tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sent[i] = $urandom; in_valid = 1'b1; in_data = sent[i];
            tick();
        end
        in_valid = 1'b0;
        n_vec++; if (fcount !== (AW+1)'(DEPTH)) begin n_err++; $display("FAIL ovf_count got %0d want %0d", fcount, DEPTH); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b want 1", ovf); end
        tready = 1'b1;
        for (int c = 0; c < 60 && got_d.size() < 20; c++) begin
            if (tvalid) begin
                got_d.push_back(tdata);
                n_vec++; if (tdata !== m_hold) begin n_err++; $display("FAIL ovf_model_data got %h want %h", tdata, m_hold); end
            end
            tick();
        end
        n_vec++; if (got_d.size() != 18) begin n_err++; $display("FAIL ovf_drain_beats got %0d want 18", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 18; i++) begin
            n_vec++; if (got_d[i] !== sent[i / 2]) begin n_err++; $display("FAIL ovf_drain beat%0d got %h want %h", i, got_d[i], sent[i / 2]); end
        end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %0b want 1", ovf); end
        n_vec++; if (fcount !== '0) begin n_err++; $display("FAIL ovf_empty got %0d want 0", fcount); end
    endtask

    task automatic test_full_pop();
        apply_reset();
        tready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = DW'(32'h100 + i); tick();
        end
        in_valid = 1'b0;
        n_vec++; if (fcount !== (AW+1)'(DEPTH)) begin n_err++; $display("FAIL fullpop_fill got %0d want %0d", fcount, DEPTH); end
        tready = 1'b1; tick();              // left-beat handshake
        n_vec++; if (tlast !== 1'b1) begin n_err++; $display("FAIL fullpop_right got %0b want 1", tlast); end
        in_valid = 1'b1; in_data = 32'hBEEF_0009; tick();  // right handshake with a write
        in_valid = 1'b0; tready = 1'b0;
        n_vec++; if (fcount !== (AW+1)'(DEPTH)) begin n_err++; $display("FAIL fullpop_count got %0d want %0d", fcount, DEPTH); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf got %0b want 0", ovf); end
        n_vec++; if (tdata !== 32'h101) begin n_err++; $display("FAIL fullpop_next got %h want 101", tdata); end
        n_vec++; if (m_q[DEPTH-1] !== 32'hBEEF_0009 || fcount !== (AW+1)'(m_q.size())) begin n_err++; $display("FAIL fullpop_model got %0d want %0d", fcount, m_q.size()); end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        tready = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA_0001; tick();
        in_valid = 1'b0; tick();
        tready = 1'b1; in_valid = 1'b1; in_data = 32'hAAAA_0002; tick();
        tready = 1'b0; in_valid = 1'b0; tick();
        n_vec++; if (tlast !== 1'b1 || tvalid !== 1'b1) begin n_err++; $display("FAIL midrst_setup got v%0b l%0b want v1 l1", tvalid, tlast); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_tvalid got %0b want 0", tvalid); end
        n_vec++; if (tlast !== 1'b0) begin n_err++; $display("FAIL midrst_tlast got %0b want 0", tlast); end
        n_vec++; if (fcount !== '0) begin n_err++; $display("FAIL midrst_count got %0d want 0", fcount); end
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_stale c%0d got %0b want 0", c, tvalid); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(99) < 40);
            in_data  = $urandom;
            tready   = ($urandom_range(99) < ((c < 300) ? 70 : 35));
            tick();
            n_vec++; if (tvalid !== m_busy) begin n_err++; $display("FAIL rnd_tvalid c%0d got %0b want %0b", c, tvalid, m_busy); end
            n_vec++; if (tdata !== m_hold) begin n_err++; $display("FAIL rnd_tdata c%0d got %h want %h", c, tdata, m_hold); end
            n_vec++; if (tlast !== (m_busy && m_right)) begin n_err++; $display("FAIL rnd_tlast c%0d got %0b want %0b", c, tlast, m_busy && m_right); end
            n_vec++; if (fcount !== (AW+1)'(m_q.size())) begin n_err++; $display("FAIL rnd_count c%0d got %0d want %0d", c, fcount, m_q.size()); end
            n_vec++; if (ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf c%0d got %0b want %0b", c, ovf, m_ovf); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; tready = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
